vga_scene_engine: RTL

Parametrised VGA timing generator and scene compositor that replaces the fixed 640x480 single-car controller. It generates sync and blanking from parameterised timing and renders a grid, a frog box and NUM_CARS independently enabled car boxes. Object positions are latched once per frame to prevent tearing, and the pixel path is a fixed 2-stage pipeline. It sits between the game-logic block (positions) and the VGA DAC pins.

---
 rtl/vga_scene_engine.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_scene_engine.sv
// VGA timing generator and scene compositor: grid, frog box and NUM_CARS car boxes on a 2-stage pixel pipeline.
// Optional macro COLLISION_DETECT_EN builds the per-frame frog/car collision detector.

module vga_scene_engine #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned NUM_CARS   = 10,
  parameter int unsigned OBJ_SIZE   = 32,
  parameter int unsigned GRID_SHIFT = 5,
  parameter bit          SYNC_POL   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               frog_x,
  input  logic [9:0]               frog_y,
  input  logic [10*NUM_CARS-1:0]   car_x,
  input  logic [10*NUM_CARS-1:0]   car_y,
  input  logic [NUM_CARS-1:0]      car_en,
  output logic [2:0]               red,
  output logic [2:0]               green,
  output logic [2:0]               blue,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start,
  output logic                     collision,
  output logic [3:0]               collision_idx
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = 10;
  localparam int unsigned CW      = 11;
  localparam logic [8:0]  RGB_GREEN = 9'b000_111_000;
  localparam logic [8:0]  RGB_RED   = 9'b111_000_000;
  localparam logic [8:0]  RGB_GRID  = 9'b100_100_100;

  // Stage 0: raster counters
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          frame_end_c;

  always_comb begin
    h_d         = h_q + HW'(1);
    v_d         = v_q;
    frame_end_c = 1'b0;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      if (v_q == VW'(V_TOTAL - 1)) begin
        v_d         = '0;
        frame_end_c = 1'b1;
      end else begin
        v_d = v_q + VW'(1);
      end
    end
  end

  // Shadow copies of object positions, refreshed only at the last counter position of a frame
  logic [PW-1:0]          frog_x_q, frog_y_q;
  logic [PW*NUM_CARS-1:0] car_x_q, car_y_q;
  logic [NUM_CARS-1:0]    car_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      frog_x_q <= '0;
      frog_y_q <= '0;
      car_x_q  <= '0;
      car_y_q  <= '0;
      car_en_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (frame_end_c) begin
        frog_x_q <= frog_x;
        frog_y_q <= frog_y;
        car_x_q  <= car_x;
        car_y_q  <= car_y;
        car_en_q <= car_en;
      end
    end
  end

  // Box hit test widened to 11 bits so x+OBJ_SIZE never wraps back to the left edge
  function automatic logic obj_hit(input logic [PW-1:0] ox, input logic [PW-1:0] oy,
                                   input logic [CW-1:0] h, input logic [CW-1:0] v);
    logic [CW-1:0] x0;
    logic [CW-1:0] y0;
    x0 = CW'(ox);
    y0 = CW'(oy);
    return (h >= x0) && (h < x0 + CW'(OBJ_SIZE)) && (v >= y0) && (v < y0 + CW'(OBJ_SIZE));
  endfunction

  // Stage 1: per-pixel classification
  logic                active_s1_q, active_s1_d;
  logic                grid_s1_q, grid_s1_d;
  logic                frog_s1_q, frog_s1_d;
  logic [NUM_CARS-1:0] car_s1_q, car_s1_d;
  logic                hs_s1_q, hs_s1_d;
  logic                vs_s1_q, vs_s1_d;
  logic                frame_s1_q, frame_s1_d;
  logic [CW-1:0]       hx_c, vy_c;

  always_comb begin
    hx_c        = CW'(h_q);
    vy_c        = CW'(v_q);
    active_s1_d = (hx_c < CW'(H_DISPLAY)) && (vy_c < CW'(V_DISPLAY));
    grid_s1_d   = (h_q[GRID_SHIFT-1:0] == '0) || (v_q[GRID_SHIFT-1:0] == '0);
    frog_s1_d   = obj_hit(frog_x_q, frog_y_q, hx_c, vy_c);
    car_s1_d    = '0;
    for (int i = 0; i < int'(NUM_CARS); i++) begin
      car_s1_d[i] = car_en_q[i] && obj_hit(car_x_q[PW*i +: PW], car_y_q[PW*i +: PW], hx_c, vy_c);
    end
    hs_s1_d    = (hx_c >= CW'(H_DISPLAY + H_FP)) && (hx_c < CW'(H_DISPLAY + H_FP + H_SYNC));
    vs_s1_d    = (vy_c >= CW'(V_DISPLAY + V_FP)) && (vy_c < CW'(V_DISPLAY + V_FP + V_SYNC));
    frame_s1_d = (h_q == '0) && (v_q == '0);
  end

  // Stage 2: colour priority and sync polarity
  logic [8:0] rgb_q, rgb_d;
  logic       hs_q, hs_d, vs_q, vs_d, fs_q;

  always_comb begin
    rgb_d = '0;
    if (active_s1_q) begin
      if (frog_s1_q)       rgb_d = RGB_GREEN;
      else if (|car_s1_q)  rgb_d = RGB_RED;
      else if (grid_s1_q)  rgb_d = RGB_GRID;
    end
    hs_d = hs_s1_q ? SYNC_POL : ~SYNC_POL;
    vs_d = vs_s1_q ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_s1_q <= 1'b0;
      grid_s1_q   <= 1'b0;
      frog_s1_q   <= 1'b0;
      car_s1_q    <= '0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      frame_s1_q  <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      fs_q        <= 1'b0;
    end else begin
      active_s1_q <= active_s1_d;
      grid_s1_q   <= grid_s1_d;
      frog_s1_q   <= frog_s1_d;
      car_s1_q    <= car_s1_d;
      hs_s1_q     <= hs_s1_d;
      vs_s1_q     <= vs_s1_d;
      frame_s1_q  <= frame_s1_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= frame_s1_q;
    end
  end

  assign red         = rgb_q[8:6];
  assign green       = rgb_q[5:3];
  assign blue        = rgb_q[2:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;

`ifdef COLLISION_DETECT_EN
  // Sticky overlap flag for the frame in flight; published together with frame_start
  logic       sticky_q, sticky_d, coll_q, coll_d, hit_now_c;
  logic [3:0] sidx_q, sidx_d, cidx_q, cidx_d, low_idx_c;

  always_comb begin
    hit_now_c = active_s1_q && frog_s1_q && (|car_s1_q);
    low_idx_c = '0;
    for (int i = int'(NUM_CARS) - 1; i >= 0; i--) begin
      if (car_s1_q[i]) low_idx_c = 4'(i);
    end
    sticky_d = sticky_q;
    sidx_d   = sidx_q;
    coll_d   = coll_q;
    cidx_d   = cidx_q;
    if (frame_s1_q) begin
      coll_d   = sticky_q;
      cidx_d   = sidx_q;
      sticky_d = hit_now_c;
      sidx_d   = hit_now_c ? low_idx_c : 4'd0;
    end else if (hit_now_c) begin
      sticky_d = 1'b1;
      if (!sticky_q || (low_idx_c < sidx_q)) sidx_d = low_idx_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      sidx_q   <= '0;
      coll_q   <= 1'b0;
      cidx_q   <= '0;
    end else begin
      sticky_q <= sticky_d;
      sidx_q   <= sidx_d;
      coll_q   <= coll_d;
      cidx_q   <= cidx_d;
    end
  end

  assign collision     = coll_q;
  assign collision_idx = cidx_q;
`else
  assign collision     = 1'b0;
  assign collision_idx = 4'd0;
`endif

endmodule
